// File: rtl/sap_pkg.sv
// Shared SAP constants and the program-loader state encoding.
// The address/data defaults are also used by the SAP RAM.
package sap_pkg;
  localparam int         SAP_ADDR_W = 4;
  localparam int         SAP_DATA_W = 8;
  localparam logic [7:0] SAP_FILL   = 8'hAA;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;
endpackage

// File: rtl/sap_ld_csum.sv
// Modulo-2**DATA_W running checksum with clear/add and a zero test
// of (sum + probe), used to validate the trailing checksum word.
module sap_ld_csum
  import sap_pkg::*;
#(
  parameter int DATA_W = SAP_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              add,
  input  logic [DATA_W-1:0] val,
  input  logic [DATA_W-1:0] probe,
  output logic              zero
);
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] tot;

  // clr together with add loads val, so the length word seeds the sum
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   sum <= '0;
    else if (clr) sum <= add ? val : '0;
    else if (add) sum <= sum + val;
  end

  assign tot  = sum + probe;
  assign zero = (tot == '0);
endmodule

// File: rtl/sap_prog_loader.sv
// SAP RAM program loader: clears RAM to FILL, then loads a length-prefixed,
// checksummed stream from address 0 and releases the CPU on a clean frame.
module sap_prog_loader
  import sap_pkg::*;
#(
  parameter int                ADDR_W = SAP_ADDR_W,
  parameter int                DATA_W = SAP_DATA_W,
  parameter logic [DATA_W-1:0] FILL   = DATA_W'(SAP_FILL)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW    = DATA_W + 1;

  generate
    if (DATA_W <= ADDR_W) begin : g_param_chk
      $error("sap_prog_loader: DATA_W must exceed ADDR_W");
    end
  endgenerate

  state_t          state;
  logic [CW-1:0]   count;
  logic [CW-1:0]   len;
  logic [CW-1:0]   l_ext;
  logic [CW-1:0]   count_nxt;
  logic            xfer;
  logic            len_bad;
  logic            last_data;
  logic            csum_clr;
  logic            csum_add;
  logic            csum_zero;

  assign xfer      = in_valid & in_ready;
  assign l_ext     = {1'b0, in_data};
  assign len_bad   = (l_ext == '0) || (l_ext > CW'(DEPTH));
  assign count_nxt = count + 1'b1;
  assign last_data = (count_nxt == len);
  assign csum_clr  = xfer && (state == LEN);
  assign csum_add  = xfer && ((state == LEN) || (state == DATA));

  sap_ld_csum #(.DATA_W(DATA_W)) u_csum (
    .clk   (clk),
    .reset (reset),
    .clr   (csum_clr),
    .add   (csum_add),
    .val   (in_data),
    .probe (in_data),
    .zero  (csum_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cpu_hold  <= 1'b1;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      count     <= '0;
      len       <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          // first clear write is issued on the launching edge
          if (start) begin
            state     <= CLEAR;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_hold  <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= FILL;
          end
        end
        CLEAR: begin
          if (mem_addr == ADDR_W'(DEPTH - 1)) begin
            state    <= LEN;
            in_ready <= 1'b1;
          end else begin
            mem_we   <= 1'b1;
            mem_addr <= mem_addr + 1'b1;
          end
        end
        LEN: begin
          if (xfer) begin
            if (len_bad) begin
              state    <= ERR;
              err      <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              len   <= l_ext;
              count <= '0;
              state <= DATA;
            end
          end
        end
        DATA: begin
          // count never exceeds len-1 here, so the address cannot wrap
          if (xfer) begin
            mem_we    <= 1'b1;
            mem_addr  <= count[ADDR_W-1:0];
            mem_wdata <= in_data;
            count     <= count_nxt;
            if (last_data) state <= CSUM;
          end
        end
        CSUM: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (csum_zero) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
